uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter among NREQ byte sources (register read-back FSM, status reporter, waveform event logger) with rotating-priority arbitration. Sits between the requesters and the transceiver's tx_data/tx_wr/tx_done port. It serialises bytes one at a time. It can optionally hold the grant so one requester sends a multi-byte frame without interleaving.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT_CYC, 16'hFFFF: watchdog limit in clk cycles for tx_done_i. Used only with the timeout feature.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-requester byte request.
- lock_i  in  NREQ  per-requester grant hold for multi-byte frames.
- data_i  in  8*NREQ  flattened bytes; requester k uses bits [8k+7:8k].
- ack_o  out  NREQ  one-cycle pulse when requester's byte is accepted.
- tx_data_o  out  8  byte to transceiver; registered.
- tx_wr_o  out  1  one-cycle start pulse to transceiver.
- tx_done_i  in  1  transceiver byte-complete pulse.
- busy_o  out  1  high whenever the state is not IDLE.
- owner_o  out  $clog2(NREQ)  index of the current/last granted requester.
- timeout_o  out  1  sticky watchdog error flag.

## Operation
- States:
  - IDLE: no byte in flight.
  - ISSUE: start pulse being sent.
  - WAIT_DONE: waiting for the transceiver to finish.
- IDLE:
  - If any req_i is high, grant the first requester searching upward from rr_ptr, wrapping modulo NREQ.
  - On the grant edge: tx_data_o <= data_i[g], ack_o[g] <= 1, owner_o <= g, state -> ISSUE.
  - If no req_i is high, stay in IDLE.
- ISSUE: tx_wr_o <= 1 for exactly one cycle, then state -> WAIT_DONE.
- WAIT_DONE: on tx_done_i:
  - If lock_i[owner] & req_i[owner]: re-grant the owner directly, with the same actions as an IDLE grant and no arbitration.
  - Otherwise: rr_ptr <= (owner+1) mod NREQ, state -> IDLE.
- Requester protocol: hold req_i and data_i stable until ack_o is seen. Deassert req_i, or present the next byte, in the cycle after ack_o.
- Lock is sampled only at tx_done_i. If lock_i is high while req_i is low, the grant is released; the arbiter never stalls waiting for a locked requester.
- tx_done_i is ignored in IDLE and ISSUE.
- tx_data_o holds its value until the next grant.
- Reset values:
  - Outputs: ack_o 0, tx_wr_o 0, tx_data_o 8'h00, busy_o 0, owner_o 0, timeout_o 0.
  - Internal: rr_ptr 0, state IDLE.
- Reset mid-operation abandons the in-flight byte. The next grant restarts from requester 0.

## Timing
- Request seen in IDLE at cycle 0:
  - ack_o and tx_data_o valid in cycle 1.
  - tx_wr_o high in cycle 2.
  - busy_o high from cycle 1.
- tx_done_i at cycle T in WAIT_DONE:
  - No locked continuation: IDLE in cycle T+1; a new grant (ack_o) can appear in cycle T+2.
  - Locked continuation: ack_o in cycle T+1 and tx_wr_o in cycle T+2.
- Simultaneous requests from all NREQ sources are served in rotation, e.g. 0,1,2,3,0,… One byte each per round unless lock_i is held.

## Configuration
- UART_TX_ARB_TIMEOUT_EN defined:
  - A 16-bit watchdog clears on entering WAIT_DONE and increments every WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYC-1 without tx_done_i: abort. rr_ptr <= owner+1, state -> IDLE, timeout_o <= 1 and stays set until reset.
  - If tx_done_i arrives in that same terminal cycle, tx_done_i wins and no timeout occurs.
- UART_TX_ARB_TIMEOUT_EN undefined: no counter is built, timeout_o is tied to 0, and WAIT_DONE waits indefinitely.

## Structure
- Package uart_tx_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_DONE);
  - default TIMEOUT_CYC constant;
  - owner-width helper function.
- Sub-module uart_rr_pick: combinational rotating-priority picker. Inputs are req vector and rr_ptr; outputs are grant index and a valid flag.
- The arbiter instantiates uart_rr_pick once and holds the state machine, registered outputs and the optional watchdog.

## Test plan
- Single request: req_i=4'b0100, data_i[2]=8'hA5.
  - Expect ack_o[2] in cycle 1, tx_data_o=8'hA5, tx_wr_o in cycle 2, owner_o=2.
  - After tx_done_i, expect busy_o 0 one cycle later.
- Contention: req_i=4'b1111 held with distinct bytes.
  - Transmitted order is 0,1,2,3,0.
  - Exactly one tx_wr_o per tx_done_i.
- Lock: requester 1 holds lock_i[1] for 3 bytes while requester 3 also requests.
  - Expect 3 consecutive grants to 1, then 3.
  - Re-grant ack_o arrives the cycle after tx_done_i.
- Spurious done: tx_done_i pulsed in IDLE and in ISSUE.
  - Expect no state change and no extra ack_o or tx_wr_o.
- Reset mid-byte: rst_n asserted in WAIT_DONE.
  - All outputs return to reset values.
  - After release, req_i=4'b1000 is granted with owner_o=3.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=20, tx_done_i never returns:
  - timeout_o sets 20 cycles after WAIT_DONE entry and stays sticky.
  - The next requester is granted.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Optional watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    localparam logic [15:0] TIMEOUT_CYC_DEFAULT = 16'hFFFF;

    // Index width for a requester count; never narrower than one bit.
    function automatic int owner_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr_i,
// wrapping modulo NREQ.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = owner_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [W-1:0]    ptr_i,
    output logic [W-1:0]    grant_o,
    output logic            valid_o
);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid_o && req_i[W'((int'(ptr_i) + i) % NREQ)]) begin
                valid_o = 1'b1;
                grant_o = W'((int'(ptr_i) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Rotating-priority arbiter sharing one UART transmitter among NREQ byte sources,
// with per-requester grant hold. Define UART_TX_ARB_TIMEOUT_EN for the tx_done watchdog.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int          NREQ        = 4,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         lock_i,
    input  logic [8*NREQ-1:0]       data_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_wr_o,
    input  logic                    tx_done_i,
    output logic                    busy_o,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    timeout_o
);

    localparam int W = owner_width(NREQ);

    localparam logic [1:0] ST_IDLE      = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE     = 2'(ISSUE);
    localparam logic [1:0] ST_WAIT_DONE = 2'(WAIT_DONE);

    // Handshake: a requester holds req_i/data_i until its one-cycle ack_o pulse;
    // the byte is captured on that edge, so the requester may move on the next cycle.

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic [W-1:0]    owner_q, owner_d;
    logic [W-1:0]    rr_q, rr_d;
    logic [W-1:0]    pick_idx;
    logic            pick_valid;
    logic            do_grant;
    logic [W-1:0]    grant_idx;
    logic            relock;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0]     wd_q, wd_d;
    logic            timeout_q, timeout_d;
`else
    logic            unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    function automatic logic [W-1:0] next_idx(input logic [W-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    endfunction

    uart_rr_pick #(.NREQ(NREQ), .W(W)) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_q),
        .grant_o (pick_idx),
        .valid_o (pick_valid)
    );

    assign relock = lock_i[owner_q] & req_i[owner_q];

    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        owner_d   = owner_q;
        rr_d      = rr_q;
        do_grant  = 1'b0;
        grant_idx = owner_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                do_grant  = pick_valid;
                grant_idx = pick_idx;
            end
            ST_ISSUE: begin
                tx_wr_d = 1'b1;
                state_d = ST_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            ST_WAIT_DONE: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
`endif
                // A locked owner with another byte ready skips arbitration entirely.
                if (tx_done_i) begin
                    if (relock) begin
                        do_grant = 1'b1;
                    end else begin
                        rr_d    = next_idx(owner_q);
                        state_d = ST_IDLE;
                    end
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (wd_q == TIMEOUT_CYC - 16'd1) begin
                    rr_d      = next_idx(owner_q);
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_grant) begin
            state_d   = ST_ISSUE;
            ack_d     = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
            tx_data_d = data_i[{grant_idx, 3'b000} +: 8];
            owner_d   = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= '0;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            owner_q   <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign ack_o     = ack_q;
    assign tx_data_o = tx_data_q;
    assign tx_wr_o   = tx_wr_q;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester and transceiver models plus a
// byte scoreboard keyed on tx_wr_o.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_i = '0;
    logic [NREQ-1:0]   lock_i = '0;
    logic [8*NREQ-1:0] data_i = '0;
    logic [NREQ-1:0]   ack_o;
    logic [7:0]        tx_data_o;
    logic              tx_wr_o;
    logic              tx_done_i = 1'b0;
    logic              busy_o;
    logic [1:0]        owner_o;
    logic              timeout_o;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(16'd20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .lock_i    (lock_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .tx_data_o (tx_data_o),
        .tx_wr_o   (tx_wr_o),
        .tx_done_i (tx_done_i),
        .busy_o    (busy_o),
        .owner_o   (owner_o),
        .timeout_o (timeout_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester model: byte lists per source, advanced the cycle after ack_o
    logic [7:0]      src_mem [NREQ][16];
    int              src_cnt [NREQ];
    int              src_rd  [NREQ];
    logic [NREQ-1:0] lock_mode = '0;
    logic [NREQ-1:0] ack_prev = '0;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (!rst_n) src_rd[k] = src_cnt[k];
            else if (ack_prev[k]) src_rd[k] = src_rd[k] + 1;
        end
        ack_prev = rst_n ? ack_o : '0;
        for (int k = 0; k < NREQ; k++) begin
            req_i[k]          = (src_cnt[k] > src_rd[k]);
            lock_i[k]         = lock_mode[k] && (src_cnt[k] > src_rd[k]);
            data_i[8*k +: 8]  = (src_cnt[k] > src_rd[k]) ? src_mem[k][src_rd[k] % 16] : 8'h00;
        end
    end

    // Transceiver model: auto tx_done_i a fixed delay after tx_wr_o, or manual pulses
    logic xcvr_en = 1'b0;
    logic manual_done = 1'b0;
    logic tx_pulse;
    int   done_cnt = 0;
    int   done_delay = 3;

    always @(posedge clk) begin
        #1;
        tx_pulse = 1'b0;
        if (!xcvr_en || !rst_n) done_cnt = 0;
        else if (tx_wr_o) done_cnt = done_delay;
        else if (done_cnt != 0) begin
            done_cnt = done_cnt - 1;
            if (done_cnt == 0) tx_pulse = 1'b1;
        end
        tx_done_i = manual_done | tx_pulse;
    end

    // Scoreboard: every tx_wr_o pops one expected {owner, byte}
    int wr_total = 0;
    int done_total = 0;
    int ack_total = 0;

    always @(negedge clk) begin
        if (rst_n && tx_wr_o) begin
            wr_total++;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected_wr: observed owner %0d byte %0h with empty queue", owner_o, tx_data_o);
            end
            if (exp_q.size() != 0) check("sb_owner_byte", {22'd0, owner_o, tx_data_o}, {22'd0, exp_q.pop_front()});
        end
        if (rst_n && tx_done_i) done_total++;
        if (rst_n) ack_total += $countones(ack_o);
    end

    // Driver tasks
    task automatic load(input int k, input logic [7:0] b);
        src_mem[k][src_cnt[k] % 16] = b;
        src_cnt[k] = src_cnt[k] + 1;
    endtask

    task automatic expect_tx(input int k, input logic [7:0] b);
        exp_q.push_back({2'(k), b});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (tx_done_i === 1'b1) break;
        end
        check(tag, {31'd0, tx_done_i}, 32'd1);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy_o === 1'b0 && req_i == '0) break;
        end
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, {28'd0, ack_o}, 32'd0);
        check({tag, "_wr"}, {31'd0, tx_wr_o}, 32'd0);
        check({tag, "_data"}, {24'd0, tx_data_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_owner"}, {30'd0, owner_o}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed time %0t", $time);
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int wr0, done0, ack0;

        // Reset state
        cyc(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        xcvr_en = 1'b1;
        cyc(2);

        // Contention: all four request, source 0 has two bytes
        wr0 = wr_total; done0 = done_total;
        load(0, 8'hC0); load(0, 8'hC4); load(1, 8'hC1); load(2, 8'hC2); load(3, 8'hC3);
        expect_tx(0, 8'hC0); expect_tx(1, 8'hC1); expect_tx(2, 8'hC2);
        expect_tx(3, 8'hC3); expect_tx(0, 8'hC4);
        drain("contention", 200);
        check("contention_wr_count", wr_total - wr0, 32'd5);
        check("contention_done_count", done_total - done0, 32'd5);

        // Lock: source 1 sends three bytes back to back while source 3 waits
        lock_mode = 4'b0010;
        load(1, 8'hB1); load(1, 8'hB2); load(1, 8'hB3); load(3, 8'hD3);
        expect_tx(1, 8'hB1); expect_tx(1, 8'hB2); expect_tx(1, 8'hB3); expect_tx(3, 8'hD3);
        wait_done("lock_done1", 50);
        cyc(1);
        check("lock_regrant1_ack", {28'd0, ack_o}, 32'h2);
        wait_done("lock_done2", 50);
        cyc(1);
        check("lock_regrant2_ack", {28'd0, ack_o}, 32'h2);
        wait_done("lock_done3", 50);
        cyc(1);
        check("lock_release_ack", {28'd0, ack_o}, 32'h0);
        check("lock_release_busy", {31'd0, busy_o}, 32'd0);
        cyc(1);
        check("lock_next_ack", {28'd0, ack_o}, 32'h8);
        check("lock_next_owner", {30'd0, owner_o}, 32'd3);
        drain("lock", 100);
        lock_mode = '0;

        // Single request timing
        load(2, 8'hA5);
        expect_tx(2, 8'hA5);
        cyc(1);
        check("single_c0_ack", {28'd0, ack_o}, 32'h0);
        cyc(1);
        check("single_c1_ack", {28'd0, ack_o}, 32'h4);
        check("single_c1_data", {24'd0, tx_data_o}, 32'hA5);
        check("single_c1_owner", {30'd0, owner_o}, 32'd2);
        check("single_c1_busy", {31'd0, busy_o}, 32'd1);
        check("single_c1_wr", {31'd0, tx_wr_o}, 32'd0);
        cyc(1);
        check("single_c2_wr", {31'd0, tx_wr_o}, 32'd1);
        check("single_c2_ack", {28'd0, ack_o}, 32'h0);
        wait_done("single_done", 50);
        check("single_busy_at_done", {31'd0, busy_o}, 32'd1);
        cyc(1);
        check("single_busy_after_done", {31'd0, busy_o}, 32'd0);
        check("single_data_held", {24'd0, tx_data_o}, 32'hA5);

        // Spurious tx_done_i in IDLE
        xcvr_en = 1'b0;
        cyc(2);
        wr0 = wr_total; ack0 = ack_total;
        manual_done = 1'b1;
        cyc(1);
        manual_done = 1'b0;
        cyc(3);
        check("spur_idle_busy", {31'd0, busy_o}, 32'd0);
        check("spur_idle_wr_count", wr_total - wr0, 32'd0);
        check("spur_idle_ack_count", ack_total - ack0, 32'd0);

        // Spurious tx_done_i in ISSUE
        ack0 = ack_total;
        load(0, 8'h5A);
        expect_tx(0, 8'h5A);
        cyc(1);
        manual_done = 1'b1;
        cyc(1);
        manual_done = 1'b0;
        check("spur_issue_ack", {28'd0, ack_o}, 32'h1);
        cyc(1);
        check("spur_issue_wr", {31'd0, tx_wr_o}, 32'd1);
        cyc(2);
        check("spur_issue_still_busy", {31'd0, busy_o}, 32'd1);
        check("spur_issue_no_rewr", {31'd0, tx_wr_o}, 32'd0);
        manual_done = 1'b1;
        cyc(1);
        manual_done = 1'b0;
        cyc(1);
        check("spur_issue_done_busy", {31'd0, busy_o}, 32'd0);
        check("spur_issue_ack_count", ack_total - ack0, 32'd1);

        // Reset in WAIT_DONE
        load(2, 8'h77);
        expect_tx(2, 8'h77);
        cyc(4);
        check("midreset_busy_before", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        cyc(1);
        check_reset_outputs("midreset");
        cyc(1);
        rst_n = 1'b1;
        xcvr_en = 1'b1;
        cyc(1);
        load(3, 8'h3C);
        expect_tx(3, 8'h3C);
        cyc(2);
        check("post_reset_ack", {28'd0, ack_o}, 32'h8);
        check("post_reset_owner", {30'd0, owner_o}, 32'd3);
        check("post_reset_data", {24'd0, tx_data_o}, 32'h3C);
        drain("post_reset", 100);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog: source 0 never completes, source 1 is served next
        xcvr_en = 1'b0;
        cyc(1);
        load(0, 8'hE0); load(1, 8'hE1);
        expect_tx(0, 8'hE0); expect_tx(1, 8'hE1);
        cyc(3);
        check("wd_c2_wr", {31'd0, tx_wr_o}, 32'd1);
        cyc(19);
        check("wd_c21_timeout", {31'd0, timeout_o}, 32'd0);
        check("wd_c21_busy", {31'd0, busy_o}, 32'd1);
        cyc(1);
        check("wd_c22_timeout", {31'd0, timeout_o}, 32'd1);
        check("wd_c22_busy", {31'd0, busy_o}, 32'd0);
        xcvr_en = 1'b1;
        cyc(1);
        check("wd_next_ack", {28'd0, ack_o}, 32'h2);
        check("wd_next_owner", {30'd0, owner_o}, 32'd1);
        drain("wd", 100);
        check("wd_sticky", {31'd0, timeout_o}, 32'd1);
`else
        check("timeout_tied_low", {31'd0, timeout_o}, 32'd0);
`endif

        cyc(2);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
